// File: rtl/pdm_pkg.sv
// Shared types and constants for the PDM microphone receiver and its CIC decimator.
package pdm_pkg;

  localparam int ACC_W         = 24;
  localparam int CIC_ORDER     = 3;
  localparam int PCM_W         = 16;
  localparam int WARMUP_FRAMES = 3;

  typedef logic signed [ACC_W-1:0] acc_t;
  typedef logic signed [PCM_W-1:0] pcm_t;

  localparam acc_t PCM_MAX = 24'sh007FFF;
  localparam acc_t PCM_MIN = 24'shFF8000;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_WARMUP = 2'd1,
    RX_RUN    = 2'd2
  } rx_state_t;

  // A PDM one counts as +1 and a zero as -1 in the accumulator domain.
  function automatic acc_t pdm_to_acc(input logic b);
    acc_t r;
    if (b) begin
      r = {{(ACC_W-1){1'b0}}, 1'b1};
    end else begin
      r = {ACC_W{1'b1}};
    end
    return r;
  endfunction

  function automatic pcm_t sat_pcm(input acc_t v);
    pcm_t r;
    if (v > PCM_MAX) begin
      r = 16'sh7FFF;
    end else if (v < PCM_MIN) begin
      r = 16'sh8000;
    end else begin
      r = pcm_t'(v[PCM_W-1:0]);
    end
    return r;
  endfunction

endpackage

// File: rtl/pdm_mic_rx_if.sv
// PCM sample bus from the microphone receiver to downstream audio logic.
interface pdm_mic_rx_if;
  import pdm_pkg::*;

  pcm_t pcm_data;
  logic pcm_valid;

  modport master (output pcm_data, output pcm_valid);
  modport slave  (input  pcm_data, input  pcm_valid);
endinterface

// File: rtl/pdm_mic_rx_cic3_decimator.sv
// Third-order CIC decimator: integrators on every sample strobe, combs once per frame,
// then shift, saturate and a one-cycle valid strobe three clocks after the frame-ending strobe.
module cic3_decimator
  import pdm_pkg::*;
#(
  parameter int DECIM = 50,
  parameter int SHIFT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic strobe,
  input  acc_t x,
  input  logic out_en,
  output logic frame_done,
  output pcm_t pcm_data,
  output logic pcm_valid
);

  localparam int   FC_W     = $clog2(DECIM);
  localparam acc_t ACC_ZERO = {ACC_W{1'b0}};

  logic [FC_W-1:0] frame_cnt_r;
  acc_t            i1_r, i2_r, i3_r;
  acc_t            d1_r, d2_r, d3_r, c3_r;
  acc_t            c1_s, c2_s, c3_s, y_s;
  logic            fe1_r, fe2_r;
  logic            pcm_valid_r;
  pcm_t            pcm_data_r;

  // Integrators and frame counter; wrap-around of the accumulators is intended.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i1_r        <= ACC_ZERO;
      i2_r        <= ACC_ZERO;
      i3_r        <= ACC_ZERO;
      frame_cnt_r <= {FC_W{1'b0}};
      fe1_r       <= 1'b0;
    end else if (clear) begin
      i1_r        <= ACC_ZERO;
      i2_r        <= ACC_ZERO;
      i3_r        <= ACC_ZERO;
      frame_cnt_r <= {FC_W{1'b0}};
      fe1_r       <= 1'b0;
    end else if (strobe) begin
      i1_r <= i1_r + x;
      i2_r <= i2_r + i1_r;
      i3_r <= i3_r + i2_r;
      if (frame_cnt_r == FC_W'(DECIM - 1)) begin
        frame_cnt_r <= {FC_W{1'b0}};
        fe1_r       <= 1'b1;
      end else begin
        frame_cnt_r <= frame_cnt_r + FC_W'(1);
        fe1_r       <= 1'b0;
      end
    end else begin
      fe1_r <= 1'b0;
    end
  end

  // Comb chain evaluated from the frozen i3 in the cycle after the frame end.
  always_comb begin
    c1_s = i3_r - d1_r;
    c2_s = c1_s - d2_r;
    c3_s = c2_s - d3_r;
    y_s  = c3_r >>> SHIFT;
  end

  // Comb delay registers and the comb result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d1_r  <= ACC_ZERO;
      d2_r  <= ACC_ZERO;
      d3_r  <= ACC_ZERO;
      c3_r  <= ACC_ZERO;
      fe2_r <= 1'b0;
    end else if (clear) begin
      d1_r  <= ACC_ZERO;
      d2_r  <= ACC_ZERO;
      d3_r  <= ACC_ZERO;
      c3_r  <= ACC_ZERO;
      fe2_r <= 1'b0;
    end else if (fe1_r) begin
      d1_r  <= i3_r;
      d2_r  <= c1_s;
      d3_r  <= c2_s;
      c3_r  <= c3_s;
      fe2_r <= 1'b1;
    end else begin
      fe2_r <= 1'b0;
    end
  end

  // Output register: pcm_data holds between strobes, including across a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcm_data_r  <= 16'sh0000;
      pcm_valid_r <= 1'b0;
    end else if (clear) begin
      pcm_valid_r <= 1'b0;
    end else if (fe2_r && out_en) begin
      pcm_data_r  <= sat_pcm(y_s);
      pcm_valid_r <= 1'b1;
    end else begin
      pcm_valid_r <= 1'b0;
    end
  end

  assign frame_done = fe2_r;
  assign pcm_data   = pcm_data_r;
  assign pcm_valid  = pcm_valid_r;

endmodule

// File: rtl/pdm_mic_rx.sv
// PDM microphone receiver: mic clock divider, input synchronizer, sample strobe and
// enable/warm-up control around the CIC decimator.
module pdm_mic_rx
  import pdm_pkg::*;
#(
  parameter int CLK_DIV = 10,
  parameter int DECIM   = 50,
  parameter int SHIFT   = 2,
  parameter int CHANNEL = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         pdm_in,
  output logic         mic_clk,
  pdm_mic_rx_if.master pcm
);

  localparam int DIV_W   = $clog2(CLK_DIV);
  localparam int HALF    = CLK_DIV / 2;
  localparam int STB_CNT = (CHANNEL == 0) ? (HALF - 1) : (CLK_DIV - 1);
  localparam int WC_W    = $clog2(WARMUP_FRAMES + 1);

  logic [1:0]       sync_r;
  logic [DIV_W-1:0] div_cnt_r, div_nxt_s;
  logic             mic_clk_r;
  logic             strobe_s, clear_s, frame_done_s, out_en_s;
  acc_t             x_s;
  rx_state_t        state_r, state_nxt_s;
  logic [WC_W-1:0]  warm_cnt_r;
  pcm_t             pcm_data_s;
  logic             pcm_valid_s;

  // Two-flop synchronizer for the asynchronous mic data line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], pdm_in};
    end
  end

  // Next divider count; held at zero while disabled.
  always_comb begin
    div_nxt_s = {DIV_W{1'b0}};
    if (!en) begin
      div_nxt_s = {DIV_W{1'b0}};
    end else if (div_cnt_r == DIV_W'(CLK_DIV - 1)) begin
      div_nxt_s = {DIV_W{1'b0}};
    end else begin
      div_nxt_s = div_cnt_r + DIV_W'(1);
    end
  end

  // mic_clk is decoded from the next count so it stays phase-aligned with div_cnt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_r <= {DIV_W{1'b0}};
      mic_clk_r <= 1'b0;
    end else begin
      div_cnt_r <= div_nxt_s;
      mic_clk_r <= en && (div_nxt_s < DIV_W'(HALF));
    end
  end

  // Sample strobe sits in the last system clock before the selected mic_clk edge.
  always_comb begin
    strobe_s = en && (div_cnt_r == DIV_W'(STB_CNT));
    clear_s  = ~en;
    x_s      = pdm_to_acc(sync_r[1]);
  end

  // Receiver state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= RX_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and output-enable decode.
  always_comb begin
    state_nxt_s = state_r;
    out_en_s    = 1'b0;
    case (state_r)
      RX_IDLE: begin
        if (en) begin
          state_nxt_s = RX_WARMUP;
        end else begin
          state_nxt_s = RX_IDLE;
        end
      end
      RX_WARMUP: begin
        if (!en) begin
          state_nxt_s = RX_IDLE;
        end else if (frame_done_s && (warm_cnt_r == WC_W'(WARMUP_FRAMES - 1))) begin
          state_nxt_s = RX_RUN;
        end else begin
          state_nxt_s = RX_WARMUP;
        end
      end
      RX_RUN: begin
        out_en_s = 1'b1;
        if (!en) begin
          state_nxt_s = RX_IDLE;
        end else begin
          state_nxt_s = RX_RUN;
        end
      end
      default: begin
        state_nxt_s = RX_IDLE;
      end
    endcase
  end

  // Counts discarded comb outputs while warming up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      warm_cnt_r <= {WC_W{1'b0}};
    end else if (state_r != RX_WARMUP) begin
      warm_cnt_r <= {WC_W{1'b0}};
    end else if (frame_done_s) begin
      warm_cnt_r <= warm_cnt_r + WC_W'(1);
    end else begin
      warm_cnt_r <= warm_cnt_r;
    end
  end

  cic3_decimator #(
    .DECIM (DECIM),
    .SHIFT (SHIFT)
  ) u_cic (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear_s),
    .strobe     (strobe_s),
    .x          (x_s),
    .out_en     (out_en_s),
    .frame_done (frame_done_s),
    .pcm_data   (pcm_data_s),
    .pcm_valid  (pcm_valid_s)
  );

  assign mic_clk       = mic_clk_r;
  assign pcm.pcm_data  = pcm_data_s;
  assign pcm.pcm_valid = pcm_valid_s;

endmodule
